// File: rtl/add_arbiter.sv
// Arbitrates NREQ add requesters onto one shared combinational adder and returns each sum over valid/ready.
// Define ADD_ARB_RR_EN for round-robin arbitration; the default build uses fixed lowest-index priority.
`ifndef INPUTSIZE
`define INPUTSIZE 16
`endif

module add_arbiter #(
  parameter int unsigned WIDTH = `INPUTSIZE,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_c0,
  input  logic [WIDTH:0]        add_s,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH:0]        rsp_sum,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           grant_any;
  logic [IDW-1:0] grant_id;
  logic           accept;

  assign accept = (state == IDLE) && grant_any;

`ifdef ADD_ARB_RR_EN
  logic [IDW-1:0] ptr;

  // Search starts at the pointer lane and wraps modulo NREQ.
  always_comb begin
    int unsigned idx;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_any && req_valid[IDW'(idx)]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!grant_any && req_valid[IDW'(k)]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(k);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = ADD;
      ADD:     state_nxt = RESP;
      RESP:    if (rsp_ready[rsp_id]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state != IDLE);
    if (accept)         req_ready[grant_id] = 1'b1;
    if (state == RESP)  rsp_valid[rsp_id]   = 1'b1;
  end

  // Adder operands only move on an accept so the adder stays quiet while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_a   <= '0;
      add_b   <= '0;
      add_c0  <= 1'b0;
      rsp_id  <= '0;
      rsp_sum <= '0;
    end else begin
      if (accept) begin
        add_a  <= req_a[32'(grant_id) * WIDTH +: WIDTH];
        add_b  <= req_b[32'(grant_id) * WIDTH +: WIDTH];
        add_c0 <= req_cin[grant_id];
        rsp_id <= grant_id;
      end
      if (state == ADD) rsp_sum <= add_s;
    end
  end

endmodule
